lsu_byte_sequencer: RTL and testbench

- Multi-cycle load/store sequencer placed directly upstream of the byte-wide synchronous data RAM (8-bit word, 2^ADDR_W locations, 1-cycle registered read, write-first-cycle semantics).
- Converts one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW request into 1, 2 or 4 consecutive byte accesses.
- Assembles load bytes little-endian and sign- or zero-extends them to 32 bits.
- Returns the result with a registered done pulse.

---
 rtl/lsu_byte_sequencer.sv | 175 +++++++++++++++++
 tb/tb_lsu_byte_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_byte_sequencer.sv
// lsu_byte_sequencer
// Splits one RISC-V load/store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into
// 1, 2 or 4 consecutive byte accesses on a byte-wide synchronous RAM with a
// one-cycle registered read. Load bytes are assembled little-endian and
// sign- or zero-extended to 32 bits.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   req_valid            request strobe, taken on an edge while busy=0
//   req_we               1=store, 0=load
//   req_funct3           RISC-V funct3 (access size and signedness)
//   req_addr             byte address, only [ADDR_W-1:0] used
//   req_wdata            store data
//   busy                 sequencer not idle, requests ignored
//   done                 one-cycle pulse when a request finishes
//   err                  qualifies done: illegal funct3
//   rdata                load result, held until the next load completes
//   mem_we/mem_a/mem_wd  RAM write enable, address, write data
//   mem_rd               RAM read data, valid the cycle after mem_a
module lsu_byte_sequencer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_wd,
    input  logic [7:0]        mem_rd
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_STORE  = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_LDRAIN = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    logic [2:0]  state;
    logic [1:0]  k;          // index of the byte currently on mem_a
    logic [1:0]  last;       // L-1 for the accepted request
    logic [2:0]  funct3;
    logic [31:0] wdata_sh;   // store bytes not yet presented, LSB first
    logic [23:0] byte_buf;   // load bytes 0..2; byte 3 never needs buffering

    // The upper address bits are outside the attached RAM and are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

    function automatic logic [1:0] last_index(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'h0, raw[7:0]};
            3'b101:  return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    // In LDRAIN the final byte is still on mem_rd, so it is merged directly.
    logic [31:0] assembled;
    always_comb begin
        assembled = 32'h0;
        case (last)
            2'd0:    assembled = {24'h0, mem_rd};
            2'd1:    assembled = {16'h0, mem_rd, byte_buf[7:0]};
            default: assembled = {mem_rd, byte_buf};
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= 2'd0;
            last     <= 2'd0;
            funct3   <= 3'd0;
            wdata_sh <= 32'h0;
            byte_buf <= 24'h0;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_wd   <= 8'h0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3 <= req_funct3;
                        last   <= last_index(req_funct3);
                        k      <= 2'd0;
                        if (!is_legal(req_we, req_funct3)) begin
                            state <= S_ERR;
                        end else if (req_we) begin
                            state    <= S_STORE;
                            mem_we   <= 1'b1;
                            mem_a    <= req_addr[ADDR_W-1:0];
                            mem_wd   <= req_wdata[7:0];
                            wdata_sh <= {8'h0, req_wdata[31:8]};
                        end else begin
                            state <= S_LOAD;
                            mem_a <= req_addr[ADDR_W-1:0];
                        end
                    end
                end
                S_STORE: begin
                    if (k == last) begin
                        state  <= S_IDLE;
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        k        <= k + 2'd1;
                        mem_a    <= mem_a + A_ONE;
                        mem_wd   <= wdata_sh[7:0];
                        wdata_sh <= {8'h0, wdata_sh[31:8]};
                    end
                end
                S_LOAD: begin
                    // mem_rd now carries the byte addressed one cycle earlier.
                    case (k)
                        2'd1:    byte_buf[7:0]   <= mem_rd;
                        2'd2:    byte_buf[15:8]  <= mem_rd;
                        2'd3:    byte_buf[23:16] <= mem_rd;
                        default: ;
                    endcase
                    if (k == last) begin
                        state <= S_LDRAIN;
                    end else begin
                        k     <= k + 2'd1;
                        mem_a <= mem_a + A_ONE;
                    end
                end
                S_LDRAIN: begin
                    rdata <= extend(assembled, funct3);
                    state <= S_IDLE;
                    done  <= 1'b1;
                end
                S_ERR: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    err   <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
module tb_lsu_byte_sequencer;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid, req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          busy, done, err;
    logic [31:0]   rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [7:0]    mem_wd;
    logic [7:0]    mem_rd;

    always #5 clk = ~clk;

    lsu_byte_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Byte RAM: registered read, write-first, plus a bench preload port.
    logic [7:0]    ram [DEPTH];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [7:0]    pl_d = 8'h0;
    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_we) ram[mem_a] <= mem_wd;
        mem_rd <= mem_we ? mem_wd : ram[mem_a];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int done_cyc; logic err; logic [31:0] rdata; } exp_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    exp_t done_q[$];
    wr_t  wr_q[$];

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] ref_rdata = 32'h0;
    int n_chk = 0, n_fail = 0;
    int busy_lo = 1, busy_hi = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: busy window, write stream and done/result scoreboard.
    exp_t mon_e;
    wr_t  mon_w;
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            if (mem_we) begin
                if (wr_q.size() == 0) check("unexpected_write", 32'(mem_a), 32'hFFFF_FFFF);
                else begin
                    mon_w = wr_q.pop_front();
                    check("wr_addr", 32'(mem_a), 32'(mon_w.a));
                    check("wr_data", 32'(mem_wd), 32'(mon_w.d));
                end
            end
            if (done) begin
                if (done_q.size() == 0) check("unexpected_done", 32'(done), 32'h0);
                else begin
                    mon_e = done_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
                    check("err", 32'(err), 32'(mon_e.err));
                    check("rdata", rdata, mon_e.rdata);
                end
            end else if (err) begin
                check("err_without_done", 32'(err), 32'h0);
            end
        end
    end

    task automatic poke(input int a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_a = AW'(a); pl_d = d;
        ref_mem[a] = d;
    endtask

    // Waits for idle (driving ignored junk while busy), optionally idles
    // `gap` cycles, then presents one request and records its expectation.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gap);
        int guard = 0;
        int L, lat, base, idx;
        logic legal;
        longint v;
        exp_t e;
        wr_t w;
        @(negedge clk);
        while (busy) begin
            req_valid  = 1'($urandom);
            req_we     = 1'($urandom);
            req_funct3 = 3'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            @(negedge clk);
            guard++;
            if (guard > 20) begin
                check("busy_timeout", 32'(busy), 32'h0);
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $fatal(1, "sequencer stuck busy");
            end
        end
        if (gap > 0) begin
            req_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 >= 3'd6);
        L = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        base = int'(addr % DEPTH);
        e.err = 1'b0;
        if (!legal) begin
            lat = 2; e.err = 1'b1; e.rdata = ref_rdata;
        end else if (we) begin
            lat = L + 1;
            for (int i = 0; i < L; i++) begin
                idx = (base + i) % DEPTH;
                ref_mem[idx] = 8'(wd >> (8 * i));
                w.a = AW'(idx); w.d = ref_mem[idx];
                wr_q.push_back(w);
            end
            e.rdata = ref_rdata;
        end else begin
            lat = L + 2;
            v = 0;
            for (int i = 0; i < L; i++)
                v += longint'(ref_mem[(base + i) % DEPTH]) << (8 * i);
            if (!f3[2] && L < 4 && v >= (longint'(1) << (8 * L - 1)))
                v -= (longint'(1) << (8 * L));
            ref_rdata = v[31:0];
            e.rdata = ref_rdata;
        end
        e.done_cyc = cyc + lat;
        busy_lo = cyc + 1;
        busy_hi = cyc + lat - 1;
        done_q.push_back(e);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    endtask

    task automatic drain();
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b0;
        while ((done_q.size() > 0 || busy) && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 32'(done_q.size()), 32'h0);
    endtask

    initial begin
        logic [7:0] old42, old43;
        int n0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) poke(i, 8'($urandom));
        @(negedge clk);
        pl_en = 1'b0;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_a", 32'(mem_a), 32'h0);
        check("rst_mem_wd", 32'(mem_wd), 32'h0);
        rst = 1'b0;

        poke(12'h004, 8'h11); poke(12'h005, 8'h22); poke(12'h006, 8'h33); poke(12'h007, 8'h44);
        poke(12'h020, 8'h80); poke(12'h3FF, 8'hCD); poke(12'h000, 8'hAB);
        @(negedge clk);
        pl_en = 1'b0;

        issue(1'b0, 3'b010, 32'h004, 32'h0, 0);           // LW  -> 44332211
        issue(1'b0, 3'b000, 32'h020, 32'h0, 0);           // LB  -> FFFFFF80
        issue(1'b0, 3'b100, 32'h020, 32'h0, 1);           // LBU -> 00000080
        issue(1'b0, 3'b001, 32'h3FF, 32'h0, 0);           // LH wrap -> FFFFABCD
        issue(1'b0, 3'b101, 32'h3FF, 32'h0, 0);           // LHU wrap -> 0000ABCD
        issue(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0);    // SW
        issue(1'b0, 3'b010, 32'h010, 32'h0, 0);           // LW back-to-back
        issue(1'b0, 3'b011, 32'h010, 32'h0, 0);           // illegal load
        issue(1'b1, 3'b100, 32'h010, 32'h12345678, 0);    // illegal store
        issue(1'b0, 3'b010, 32'hFFFF_F004, 32'h0, 0);     // upper bits ignored
        drain();
        check("lw_value", ref_rdata, 32'h44332211);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(DEPTH - 4, DEPTH - 1)) : $urandom;
            issue(1'($urandom), 3'($urandom), a, $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        drain();

        // Reset in the middle of an SW: only the first two bytes land.
        old42 = ref_mem[12'h042];
        old43 = ref_mem[12'h043];
        n0 = cyc;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h040; req_wdata = 32'hA1B2C3D4;
        wr_q.push_back('{a: AW'(12'h040), d: 8'hD4});
        wr_q.push_back('{a: AW'(12'h041), d: 8'hC3});
        busy_lo = n0 + 1;
        busy_hi = n0 + 2;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_mem_a", 32'(mem_a), 32'h0);
        ref_rdata = 32'h0;
        ref_mem[12'h040] = 8'hD4;
        ref_mem[12'h041] = 8'hC3;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_ram40", 32'(ram[12'h040]), 32'hD4);
        check("midrst_ram41", 32'(ram[12'h041]), 32'hC3);
        check("midrst_ram42", 32'(ram[12'h042]), 32'(old42));
        check("midrst_ram43", 32'(ram[12'h043]), 32'(old43));
        check("midrst_writes_left", 32'(wr_q.size()), 32'h0);

        issue(1'b0, 3'b010, 32'h040, 32'h0, 0);
        drain();
        check("final_writes_left", 32'(wr_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
